// File: rtl/shadow_pkg.sv
// Shared types, widths and helpers for the shadow key scheduler.
// Round keys are bytes taken from a 32-bit sliding key register.
package shadow_pkg;

  localparam int ROUNDS_DEFAULT = 32;
  localparam int KEY_W          = 32;
  localparam int RK_W           = 8;
  localparam int IDX_W          = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Rotate a round-key byte left by one bit position.
  function automatic logic [RK_W-1:0] rotl1(input logic [RK_W-1:0] x);
    return {x[RK_W-2:0], x[RK_W-1]};
  endfunction

endpackage

// File: rtl/shadow_ks_update.sv
// Next-state function of the key register: one new byte enters at the top
// while the consumed byte drops off the bottom.
module shadow_ks_update
  import shadow_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  input  logic [IDX_W-1:0] cnt,
  output logic [KEY_W-1:0] key_next
);

  logic [RK_W-1:0] new_byte;

  // The round index is mixed in so that an all-zero key still diverges.
  assign new_byte = rotl1(key[KEY_W-1 -: RK_W])
                  ^ key[RK_W-1:0]
                  ^ {{(RK_W-IDX_W){1'b0}}, cnt};

  assign key_next = {new_byte, key[KEY_W-1:RK_W]};

endmodule

// File: rtl/shadow_key_sched.sv
// Round-key scheduler: loads a 32-bit master key on start and streams
// ROUNDS byte-wide round keys over a valid/ready handshake.
module shadow_key_sched
  import shadow_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic [RK_W-1:0]  rk,
  output logic [IDX_W-1:0] rk_idx,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             rk_last,
  output logic             busy,
  output logic             done
);

  if (ROUNDS < 1 || ROUNDS > 63) begin : g_bad_rounds
    $error("shadow_key_sched: ROUNDS must be in 1..63");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  state_e           state;
  state_e           state_next;
  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] key_next;
  logic [IDX_W-1:0] cnt_q;
  logic             load;
  logic             xfer;
  logic             at_last;

  shadow_ks_update u_update (
    .key      (key_q),
    .cnt      (cnt_q),
    .key_next (key_next)
  );

  assign xfer    = (state == ST_RUN) && rk_ready;
  assign at_last = (cnt_q == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    rk_valid   = 1'b0;
    rk_last    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        rk_valid = 1'b1;
        rk_last  = at_last;
        busy     = 1'b1;
        if (rk_ready && at_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Key and index move only on load or on an accepted transfer; a stalled
  // consumer leaves both untouched for as long as it likes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      key_q <= key_in;
      cnt_q <= '0;
    end else if (xfer) begin
      key_q <= key_next;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Key outputs are straight register taps, independent of rk_ready.
  assign rk     = key_q[RK_W-1:0];
  assign rk_idx = cnt_q;

endmodule

// File: tb/tb_shadow_key_sched.sv
// Self-checking bench for shadow_key_sched: vector table, hand sequences for
// stall/reset/start-while-busy, and randomized runs against a byte-stream model.
module tb_shadow_key_sched;
  import shadow_pkg::*;

  localparam int R = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start1;
  logic [31:0] key_in, key_in1;
  logic        rk_ready, rk_ready1;
  logic [7:0]  rk, rk1;
  logic [5:0]  rk_idx, rk_idx1;
  logic        rk_valid, rk_valid1, rk_last, rk_last1;
  logic        busy, busy1, done, done1;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_rk [64];
  logic [7:0] got_rk [64];
  logic [7:0] ref_rk [64];

  typedef struct {
    logic [31:0] key;
    int          idx;
    logic [7:0]  rk;
  } vec_t;

  vec_t vecs [19];

  shadow_key_sched u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .rk(rk), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_last(rk_last), .busy(busy), .done(done)
  );

  shadow_key_sched #(.ROUNDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .key_in(key_in1),
    .rk(rk1), .rk_idx(rk_idx1), .rk_valid(rk_valid1), .rk_ready(rk_ready1),
    .rk_last(rk_last1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rot8(input logic [7:0] x);
    return 8'((x << 1) | (x >> 7));
  endfunction

  // Round keys viewed as a byte stream: the key register is a 4-byte window
  // sliding over it, so byte i+4 follows from bytes i and i+3 plus index i.
  function automatic void build_model(input logic [31:0] key, input int n);
    logic [7:0] b [$];
    b.push_back(key[7:0]);
    b.push_back(key[15:8]);
    b.push_back(key[23:16]);
    b.push_back(key[31:24]);
    for (int i = 0; i < n; i++) begin
      exp_rk[i] = b[i];
      b.push_back(rot8(b[i+3]) ^ b[i] ^ 8'(i));
    end
  endfunction

  task automatic run_sched(input logic [31:0] key, input int stall_at, input int stall_len,
                           input int poke_at, input bit rnd);
    int n = 0;
    int stalled = 0;
    int cyc = 0;
    bit poked = 1'b0;
    build_model(key, R);
    @(negedge clk);
    start = 1'b1; key_in = key; rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; key_in = $urandom;
    check("first_valid", 64'({rk_valid, rk_idx, rk}), 64'({1'b1, 6'd0, exp_rk[0]}));
    while (n < R && cyc < 2000) begin
      if (n == stall_at && stalled < stall_len) begin
        rk_ready = 1'b0;
        stalled++;
      end else if (rnd) begin
        rk_ready = ($urandom_range(0, 3) != 0);
      end else begin
        rk_ready = 1'b1;
      end
      check($sformatf("run key=%08h n=%0d", key, n),
            64'({rk_valid, rk_last, busy, done, rk_idx, rk}),
            64'({1'b1, (n == R-1), 1'b1, 1'b0, 6'(n), exp_rk[n]}));
      if (n == poke_at && !poked) begin
        start = 1'b1; key_in = 32'hFFFF_FFFF; poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (rk_valid && rk_ready) begin
        got_rk[n] = rk;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    if (n < R) begin
      check("timeout", 64'(n), 64'(R));
    end else begin
      check("done_pulse", 64'({rk_valid, busy, done}), 64'(3'b011));
      start = 1'b1; key_in = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0;
      check("idle_after_done", 64'({rk_valid, busy, done}), 64'(3'b000));
    end
    rk_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] last_key;
    int cyc;

    vecs[0]  = '{32'h0000_0000, 0, 8'h00};
    vecs[1]  = '{32'h0000_0000, 1, 8'h00};
    vecs[2]  = '{32'h0000_0000, 2, 8'h00};
    vecs[3]  = '{32'h0000_0000, 3, 8'h00};
    vecs[4]  = '{32'h0000_0000, 4, 8'h00};
    vecs[5]  = '{32'h0000_0000, 5, 8'h01};
    vecs[6]  = '{32'h0000_00A5, 0, 8'hA5};
    vecs[7]  = '{32'h0000_00A5, 1, 8'h00};
    vecs[8]  = '{32'h0000_00A5, 2, 8'h00};
    vecs[9]  = '{32'h0000_00A5, 3, 8'h00};
    vecs[10] = '{32'h0000_00A5, 4, 8'hA5};
    vecs[11] = '{32'h0000_00A5, 5, 8'h4A};
    vecs[12] = '{32'h0000_00A5, 6, 8'h96};
    vecs[13] = '{32'h0102_0304, 0, 8'h04};
    vecs[14] = '{32'h0102_0304, 1, 8'h03};
    vecs[15] = '{32'h0102_0304, 2, 8'h02};
    vecs[16] = '{32'h0102_0304, 3, 8'h01};
    vecs[17] = '{32'h0102_0304, 4, 8'h06};
    vecs[18] = '{32'h0102_0304, 5, 8'h0E};

    start = 1'b0; key_in = '0; rk_ready = 1'b0;
    start1 = 1'b0; key_in1 = '0; rk_ready1 = 1'b0;
    rst_n = 1'b0;

    // Reset held three cycles, then ten idle cycles with no start.
    repeat (3) @(negedge clk);
    check("in_reset", 64'({rk_valid, rk_last, busy, done, rk_idx, rk}), 64'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle c=%0d", i), 64'({rk_valid, rk_last, busy, done, rk_idx, rk}), 64'(0));
    end
    check("idle_r1", 64'({rk_valid1, rk_last1, busy1, done1, rk_idx1, rk1}), 64'(0));

    // Table vectors: one schedule per distinct key, then spot-check bytes.
    last_key = 32'hFFFF_FFFF;
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].key != last_key) begin
        run_sched(vecs[i].key, -1, 0, -1, 1'b0);
        last_key = vecs[i].key;
      end
      check($sformatf("tbl key=%08h idx=%0d", vecs[i].key, vecs[i].idx),
            64'(got_rk[vecs[i].idx]), 64'(vecs[i].rk));
    end

    // Backpressure at idx 3 must not change the delivered sequence.
    run_sched(32'hDEAD_BEEF, -1, 0, -1, 1'b0);
    for (int i = 0; i < R; i++) ref_rk[i] = got_rk[i];
    run_sched(32'hDEAD_BEEF, 3, 5, -1, 1'b0);
    for (int i = 0; i < R; i++)
      check($sformatf("stall_seq i=%0d", i), 64'(got_rk[i]), 64'(ref_rk[i]));

    // Start pulse while busy is ignored.
    run_sched(32'h1357_9BDF, -1, 0, 10, 1'b0);

    // Randomized keys, random backpressure, random ignored start.
    for (int k = 0; k < 4; k++)
      run_sched($urandom, -1, 0, int'($urandom_range(0, R-1)), 1'b1);

    // ROUNDS=1 instance: single key with rk_last, then done.
    @(negedge clk);
    start1 = 1'b1; key_in1 = 32'h1234_5678; rk_ready1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    check("r1_key", 64'({rk_valid1, rk_last1, busy1, done1, rk_idx1, rk1}),
          64'({1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 8'h78}));
    @(negedge clk);
    check("r1_stall", 64'({rk_valid1, rk_last1, rk_idx1, rk1}), 64'({1'b1, 1'b1, 6'd0, 8'h78}));
    rk_ready1 = 1'b1;
    @(negedge clk);
    rk_ready1 = 1'b0;
    check("r1_done", 64'({rk_valid1, rk_last1, busy1, done1}), 64'(4'b0011));
    @(negedge clk);
    check("r1_idle", 64'({rk_valid1, busy1, done1}), 64'(0));

    // Asynchronous reset in the middle of a schedule.
    @(negedge clk);
    start = 1'b1; key_in = 32'hC0FF_EE11; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (rk_idx != 6'd7 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_idx7", 64'(rk_idx), 64'(7));
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'({rk_valid, rk_last, busy, done, rk_idx, rk}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rk_ready = 1'b0;
    @(negedge clk);
    check("post_reset", 64'({rk_valid, rk_last, busy, done, rk_idx, rk}), 64'(0));
    start = 1'b1; key_in = 32'h0000_00A5;
    @(negedge clk);
    start = 1'b0;
    check("restart", 64'({rk_valid, rk_idx, rk}), 64'({1'b1, 6'd0, 8'hA5}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shadow_key_sched.md
SHADOW_KEY_SCHED -- requirements
Module: shadow_key_sched

Interface
REQ-001 Parameter ROUNDS, default 32, number of 8-bit round keys produced per start (legal range 1..63).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to load key_in and begin a schedule; honoured only in IDLE.
REQ-005 key_in  input  32  master key, sampled in the cycle start is honoured.
REQ-006 rk  output  8  current round key, driven to the downstream round cell's key input.
REQ-007 rk_idx  output  6  index of the current round key, 0..ROUNDS-1.
REQ-008 rk_valid  output  1  rk/rk_idx/rk_last are valid this cycle.
REQ-009 rk_ready  input  1  consumer accepts rk; transfer occurs when rk_valid && rk_ready.
REQ-010 rk_last  output  1  high with rk_valid when rk_idx == ROUNDS-1.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 done  output  1  one-cycle pulse after the last key is transferred.

Function
REQ-013 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 IDLE: start=1 -> K <= key_in, cnt <= 0, go to RUN next cycle; start=0 -> stay.
REQ-015 RUN: rk_valid=1, rk = K[7:0], rk_idx = cnt, all driven from registers (no combinational path from rk_ready to any output).
REQ-016 Update on transfer only: t = rotl1(K[31:24]) ^ K[7:0] ^ {2'b00,cnt}; K <= {t, K[31:8]}; cnt <= cnt+1.
REQ-017 rotl1(x) = {x[6:0], x[7]}; all arithmetic is mod 2^8 XOR, no carries.
REQ-018 rk_ready=0 in RUN -> K, cnt, rk, rk_idx held unchanged (stall), indefinitely.
REQ-019 Transfer with cnt == ROUNDS-1 -> go to DONE; no further rk_valid in that schedule.
REQ-020 DONE: done=1, rk_valid=0 for exactly one cycle, then IDLE.
REQ-021 start in RUN or DONE is ignored; K and cnt not disturbed.
REQ-022 start in the cycle DONE returns to IDLE is ignored; start is honoured from the first IDLE cycle onward.
REQ-023 First rk_valid appears one cycle after the start is honoured; with rk_ready held high, one key per cycle, ROUNDS keys in ROUNDS consecutive cycles.
REQ-024 ROUNDS=1: a single key (idx 0) with rk_last=1, then DONE.
REQ-025 cnt is 6 bits wide; it never wraps within a legal schedule.

Reset
REQ-026 rst_n low at any time, including mid-schedule, forces IDLE asynchronously; in-progress schedule is abandoned.
REQ-027 Reset values: K=0, cnt=0, rk=0x00, rk_idx=0, rk_valid=0, rk_last=0, busy=0, done=0.
REQ-028 After rst_n deasserts, no output changes until a start is honoured.

Structure
REQ-029 Shared package shadow_pkg holds: ROUNDS default, KEY_W=32, RK_W=8, IDX_W=6, the FSM state enum, and the rotl1 function.
REQ-030 One combinational sub-module, shadow_ks_update, computes K_next from (K, cnt); the FSM and registers stay in shadow_key_sched.

Verification
REQ-031 Reset/idle: rst_n low 3 cycles, released, start=0 for 10 cycles -> all outputs remain at reset values.
REQ-032 Zero key: key_in=0x00000000, start, rk_ready=1 -> rk for idx 0..5 = 00,00,00,00,00,01; rk_last only at idx 31; done pulse one cycle after idx 31 is transferred.
REQ-033 Key load: key_in=0x000000A5, start -> first rk=0xA5 with rk_idx=0, rk_valid high exactly one cycle after start.
REQ-034 Backpressure: rk_ready low 5 cycles at idx 3 -> rk, rk_idx frozen across stall; sequence after release identical to the unstalled run.
REQ-035 Start while busy: pulse start with key_in=0xFFFFFFFF at idx 10 -> ignored; remaining keys match the original key's sequence.
REQ-036 Reset mid-run: rst_n low at idx 7 -> outputs at reset values immediately; new start with key_in=0x000000A5 -> rk=0xA5, rk_idx=0.
